writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects/extracts the result and drives the register-bank write port one cycle after acceptance.
// Define WB_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to zero.
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_load_data,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  output logic        reg_write,
  output logic [4:0]  rd_sel,
  output logic [31:0] write_data,
  output logic        wb_valid,
  output logic        load_misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  logic        accept;
  logic        is_load;
  logic        misaligned;
  logic        undef_load;
  logic [31:0] byte_src;
  logic [15:0] half_src;
  logic [31:0] load_val;
  logic [31:0] result;

  logic        reg_write_d, reg_write_q;
  logic [4:0]  rd_sel_d, rd_sel_q;
  logic [31:0] write_data_d, write_data_q;
  logic        wb_valid_d, wb_valid_q;
  logic        misaligned_d, misaligned_q;

  assign in_ready = !stall;
  assign accept   = in_valid && !stall && !flush;
  assign is_load  = (in_wb_sel == WB_LOAD);

  always_comb begin
    byte_src   = in_load_data >> {in_addr_lo, 3'b000};
    half_src   = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
    load_val   = '0;
    misaligned = 1'b0;
    undef_load = 1'b0;
    case (in_funct3)
      F3_LB:  load_val = {{24{byte_src[7]}}, byte_src[7:0]};
      F3_LBU: load_val = {24'h000000, byte_src[7:0]};
      F3_LH: begin
        load_val   = {{16{half_src[15]}}, half_src};
        misaligned = in_addr_lo[0];
      end
      F3_LHU: begin
        load_val   = {16'h0000, half_src};
        misaligned = in_addr_lo[0];
      end
      F3_LW: begin
        load_val   = in_load_data;
        misaligned = (in_addr_lo != 2'b00);
      end
      default: undef_load = 1'b1;
    endcase
    misaligned = misaligned && is_load;
    undef_load = undef_load && is_load;
  end

  always_comb begin
    result = '0;
    case (in_wb_sel)
      WB_ALU:  result = in_alu_result;
      WB_LOAD: result = load_val;
      WB_PC4:  result = in_pc_plus4;
      default: result = '0;
    endcase
  end

  // rd_sel/write_data only move on acceptance so bubbles hold the last values
  always_comb begin
    reg_write_d  = accept && in_reg_write && (in_rd != 5'd0) && !misaligned
                   && !undef_load && (in_wb_sel != WB_RSVD);
    wb_valid_d   = accept && !misaligned;
    misaligned_d = accept && misaligned;
    rd_sel_d     = accept ? in_rd  : rd_sel_q;
    write_data_d = accept ? result : write_data_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      rd_sel_q     <= '0;
      write_data_q <= '0;
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_sel_q     <= rd_sel_d;
      write_data_q <= write_data_d;
      wb_valid_q   <= wb_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign reg_write       = reg_write_q;
  assign rd_sel          = rd_sel_q;
  assign write_data      = write_data_q;
  assign wb_valid        = wb_valid_q;
  assign load_misaligned = misaligned_q;

`ifdef WB_INSTRET_EN
  logic [31:0] instret_d, instret_q;

  assign instret_d = wb_valid_q ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
